lcd1602_bus_reader: RTL and testbench
=====================================

Name: lcd1602_bus_reader

Overview:
Read-side engine for the HD44780-compatible LCD1602 8-bit parallel bus. Our existing LCD path only writes, with RW tied low. This block drives RS/RW/E with RW=1 and samples the panel's data bus. It performs three operations: status reads (busy flag plus address counter), DDRAM/CGRAM data reads, and a busy-wait poll that write-side sequencers use in place of blind delays. It sits between the LCD write sequencer/arbiter and the panel pins. The top level muxes RS/E and owns the tri-state; the pin driver tri-states DB whenever lcd_rw=1.

Parameters:
T_AS, 3, clocks RS/RW valid before E rises (≥40 ns at 50 MHz)
T_PW, 13, clocks E held high (≥230 ns)
T_H, 2, clocks RS/RW held after E falls
T_REC, 10, clocks of idle recovery after each access (total cycle ≥500 ns)
POLL_TIMEOUT, 50000, clocks before a busy-wait gives up (1 ms)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-high reset
req  in  1  start request; accepted only when ready=1
op  in  2  00=status read, 01=data read, 10=busy-wait poll, 11=reserved (treated as 00)
ready  out  1  high when idle and able to accept req
done  out  1  one-cycle pulse when an operation completes
rd_data  out  8  last sampled DB byte
busy_flag  out  1  rd_data[7] from the last status read
addr  out  7  rd_data[6:0] from the last status read
timeout  out  1  set when a poll hits POLL_TIMEOUT; cleared on the next accepted req
lcd_rs  out  1  panel RS
lcd_rw  out  1  panel R/W (1 during any access)
lcd_en  out  1  panel E, registered
lcd_dat_i  in  8  panel DB as seen through the pad

Behaviour:
- Reset: async, active-high. All outputs go to zero (ready=1 is the only exception), timers clear, and the FSM enters IDLE.
  - Reset mid-access drops lcd_en immediately in the same reset assertion. No done is emitted.
- FSM states: IDLE, SETUP, EN_HI, HOLD, RECOVER.
- IDLE:
  - ready=1, lcd_en=0, lcd_rw=0.
  - On req=1 the block latches op, lcd_rs=(op==01), lcd_rw=1, clears timeout and the poll counter, and moves to SETUP.
  - ready drops the cycle after acceptance.
- SETUP: T_AS cycles, then lcd_en=1 and the FSM moves to EN_HI.
- EN_HI:
  - T_PW cycles.
  - On the last EN_HI cycle, lcd_dat_i is registered into rd_data.
  - If op≠01, busy_flag and addr update from the same sample.
  - lcd_en=0 on exit; the FSM moves to HOLD.
- HOLD: T_H cycles with RS/RW unchanged, then lcd_rw=0 and the FSM moves to RECOVER.
- RECOVER: T_REC cycles, then the exit rule applies:
  - op 00/01: done=1 for one cycle; the FSM returns to IDLE.
  - op 10, sampled busy_flag=0: done=1; the FSM returns to IDLE; timeout=0.
  - op 10, busy_flag=1, poll counter < POLL_TIMEOUT: the FSM re-enters SETUP (new status read) without returning to IDLE.
  - op 10, poll counter ≥ POLL_TIMEOUT: timeout=1, done=1; the FSM returns to IDLE.
- Timing and arithmetic:
  - Single-read latency from req acceptance to the done pulse is T_AS+T_PW+T_H+T_REC = 28 clocks with defaults.
  - done coincides with ready rising.
  - The poll counter is 16 bits. It counts every clock from acceptance and saturates at 0xFFFF, with no wrap.
  - Timeout is evaluated only at RECOVER exit, so a poll may overrun POLL_TIMEOUT by at most one access.
  - Phase timers are sized to the largest parameter; a parameter value of 0 is illegal.
- req while ready=0 is ignored (not queued).
- req held high across done starts a new operation on the first ready cycle.
- lcd_rs and lcd_rw never change while lcd_en=1.

Test Plan:
- Status read, panel model drives DB=0x45 during E → done at clock 28 after acceptance; rd_data=0x45, busy_flag=0, addr=0x45; lcd_rs=0, lcd_rw=1 for cycles 1–18; E high for exactly 13 clocks.
- Data read (op=01), DB=0xA5 → rd_data=0xA5; lcd_rs=1 throughout the access; busy_flag/addr keep their prior values.
- Busy-wait, model returns BF=1 for 3 reads then DB=0x08 → 4 E pulses, done after 4×28=112 clocks, busy_flag=0, addr=0x08, timeout=0.
- Busy-wait, BF stuck at 1 → done with timeout=1 at the first RECOVER exit where the counter ≥50000 (≤50028 clocks); the next req clears timeout.
- Assert rst for 1 clock during EN_HI → lcd_en=0, ready=1 immediately; no done pulse; a subsequent status read completes normally in 28 clocks.
- Pulse req during an active read (ready=0) → ignored; exactly one done pulse; a checker confirms RS/RW stable whenever E=1 across all tests.

Source files
------------

// File: rtl/lcd1602_bus_reader.sv
// Read-side engine for an HD44780/LCD1602 8-bit bus: status reads, data reads
// and busy-flag polling with RS/RW/E timing generated from clock-count parameters.
`timescale 1ns/1ps
module lcd1602_bus_reader #(
    parameter int T_AS         = 3,
    parameter int T_PW         = 13,
    parameter int T_H          = 2,
    parameter int T_REC        = 10,
    parameter int POLL_TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [1:0] op,
    output logic       ready,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr,
    output logic       timeout,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    input  logic [7:0] lcd_dat_i
);

    localparam int TMAX_A = (T_AS > T_PW) ? T_AS : T_PW;
    localparam int TMAX_B = (T_H > T_REC) ? T_H : T_REC;
    localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] AS_LAST  = TW'(T_AS - 1);
    localparam logic [TW-1:0] PW_LAST  = TW'(T_PW - 1);
    localparam logic [TW-1:0] H_LAST   = TW'(T_H - 1);
    localparam logic [TW-1:0] REC_LAST = TW'(T_REC - 1);
    // Limits above the 16-bit counter range clamp to the saturation value.
    localparam logic [15:0]   POLL_LIMIT = (POLL_TIMEOUT > 65535) ? 16'hFFFF : 16'(POLL_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_RECOVER
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    op_q, op_d;
    logic          rs_q, rs_d;
    logic          rw_q, rw_d;
    logic          en_q, en_d;
    logic          done_q, done_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          busy_q, busy_d;
    logic [6:0]    addr_q, addr_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   poll_q, poll_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            op_q      <= 2'b00;
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= 8'h00;
            busy_q    <= 1'b0;
            addr_q    <= 7'h00;
            timeout_q <= 1'b0;
            poll_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            op_q      <= op_d;
            rs_q      <= rs_d;
            rw_q      <= rw_d;
            en_q      <= en_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            timeout_q <= timeout_d;
            poll_q    <= poll_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        op_d      = op_q;
        rs_d      = rs_q;
        rw_d      = rw_q;
        en_d      = en_q;
        done_d    = 1'b0;
        rd_data_d = rd_data_q;
        busy_d    = busy_q;
        addr_d    = addr_q;
        timeout_d = timeout_q;
        poll_d    = poll_q;

        // The poll counter measures wall-clock time of the whole operation.
        if (state_q != S_IDLE && poll_q != 16'hFFFF) begin
            poll_d = poll_q + 16'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                en_d = 1'b0;
                rw_d = 1'b0;
                if (req) begin
                    op_d      = (op == 2'b11) ? 2'b00 : op;
                    rs_d      = (op == 2'b01);
                    rw_d      = 1'b1;
                    timeout_d = 1'b0;
                    poll_d    = 16'h0000;
                    timer_d   = '0;
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (timer_q == AS_LAST) begin
                    timer_d = '0;
                    en_d    = 1'b1;
                    state_d = S_EN_HI;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_EN_HI: begin
                if (timer_q == PW_LAST) begin
                    rd_data_d = lcd_dat_i;
                    if (op_q != 2'b01) begin
                        busy_d = lcd_dat_i[7];
                        addr_d = lcd_dat_i[6:0];
                    end
                    timer_d = '0;
                    en_d    = 1'b0;
                    state_d = S_HOLD;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_HOLD: begin
                if (timer_q == H_LAST) begin
                    timer_d = '0;
                    rw_d    = 1'b0;
                    state_d = S_RECOVER;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RECOVER: begin
                if (timer_q == REC_LAST) begin
                    timer_d = '0;
                    // A still-busy poll goes straight into another status read.
                    if (op_q == 2'b10 && busy_q && poll_q < POLL_LIMIT) begin
                        rw_d    = 1'b1;
                        state_d = S_SETUP;
                    end else begin
                        timeout_d = (op_q == 2'b10) && busy_q;
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign busy_flag = busy_q;
    assign addr      = addr_q;
    assign timeout   = timeout_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = rw_q;
    assign lcd_en    = en_q;

endmodule

// File: tb/tb_lcd1602_bus_reader.sv
// Bench for lcd1602_bus_reader: a panel model answers each E pulse from a byte
// queue, and a reference model predicts timing and results from the bus rules.
`timescale 1ns/1ps
module tb_lcd1602_bus_reader;

    localparam int ACCESS_CLKS  = 3 + 13 + 2 + 10;
    localparam int POLL_TIMEOUT = 50000;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [1:0] op;
    logic       ready;
    logic       done;
    logic [7:0] rd_data;
    logic       busy_flag;
    logic [6:0] addr;
    logic       timeout;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_dat_i = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] respQ[$];
    logic [7:0] stuckByte = 8'h00;
    int         ePulses = 0;

    logic [7:0] mRd = 8'h00;
    logic       mBusy = 1'b0;
    logic [6:0] mAddr = 7'h00;
    logic       mTimeout = 1'b0;

    logic prevEn = 1'b0;
    logic prevRs = 1'b0;
    logic prevRw = 1'b0;

    lcd1602_bus_reader dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .ready     (ready),
        .done      (done),
        .rd_data   (rd_data),
        .busy_flag (busy_flag),
        .addr      (addr),
        .timeout   (timeout),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_dat_i (lcd_dat_i)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Panel: a fresh byte appears on each E rise, junk once E falls again.
    always @(posedge lcd_en or negedge lcd_en) begin
        if (lcd_en) begin
            ePulses++;
            if (respQ.size() > 0) lcd_dat_i = respQ.pop_front();
            else lcd_dat_i = stuckByte;
        end else begin
            lcd_dat_i = 8'($urandom);
        end
    end

    always @(negedge clk) begin
        if (!rst && lcd_en && prevEn) begin
            checkOutput("rs_rw_stable_while_e", 32'({lcd_rs, lcd_rw}), 32'({prevRs, prevRw}));
        end
        prevEn = lcd_en;
        prevRs = lcd_rs;
        prevRw = lcd_rw;
    end

    task automatic applyStimulus(input logic [1:0] opIn, input bit waveChk, input int reqPulseAt);
        logic [1:0] eop;
        logic [7:0] lastByte;
        logic       expTimeout;
        int         expAcc;
        int         expLat;
        int         doneCount;
        int         pulseStart;
        int         phase;
        int         w;

        eop = (opIn == 2'b11) ? 2'b00 : opIn;
        expTimeout = 1'b0;
        expAcc = 0;
        lastByte = 8'h00;
        // Work out how many accesses the operation needs from the queued answers.
        for (int k = 1; k <= 4000; k++) begin
            lastByte = (k - 1 < respQ.size()) ? respQ[k-1] : stuckByte;
            expAcc = k;
            if (eop != 2'b10 || !lastByte[7]) break;
            if (ACCESS_CLKS * k >= POLL_TIMEOUT) begin
                expTimeout = 1'b1;
                break;
            end
        end
        expLat = ACCESS_CLKS * expAcc;

        w = 0;
        while (!ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        checkOutput("ready_before_req", 32'(ready), 32'd1);
        req = 1'b1;
        op = opIn;
        pulseStart = ePulses;
        @(posedge clk);
        #1;
        req = 1'b0;
        doneCount = 0;
        checkOutput("timeout_cleared_on_accept", 32'(timeout), 32'd0);
        for (int n = 0; n < expLat; n++) begin
            if (waveChk) begin
                phase = n % ACCESS_CLKS;
                checkOutput("lcd_rw_phase", 32'(lcd_rw), 32'(phase < 18));
                checkOutput("lcd_en_phase", 32'(lcd_en), 32'(phase >= 3 && phase <= 15));
                if (phase < 18) checkOutput("lcd_rs_phase", 32'(lcd_rs), 32'(eop == 2'b01));
                checkOutput("ready_low_busy", 32'(ready), 32'd0);
            end
            if (done) doneCount++;
            if (n == reqPulseAt) req = 1'b1;
            if (n == reqPulseAt + 1) req = 1'b0;
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        checkOutput("no_early_done", 32'(doneCount), 32'd0);
        checkOutput("done_at_latency", 32'(done), 32'd1);
        checkOutput("ready_with_done", 32'(ready), 32'd1);

        mRd = lastByte;
        if (eop != 2'b01) begin
            mBusy = lastByte[7];
            mAddr = lastByte[6:0];
        end
        mTimeout = expTimeout;
        checkOutput("rd_data", 32'(rd_data), 32'(mRd));
        checkOutput("busy_flag", 32'(busy_flag), 32'(mBusy));
        checkOutput("addr", 32'(addr), 32'(mAddr));
        checkOutput("timeout", 32'(timeout), 32'(mTimeout));
        checkOutput("e_pulse_count", 32'(ePulses - pulseStart), 32'(expAcc));

        w = 0;
        while (!done && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!done) checkOutput("done_wait_expired", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        if (reqPulseAt >= 0) begin
            doneCount = 0;
            for (int n = 0; n < 30; n++) begin
                if (done || !ready) doneCount++;
                @(posedge clk);
                #1;
            end
            checkOutput("ignored_req_no_second_op", 32'(doneCount), 32'd0);
        end
        respQ.delete();
    endtask

    initial begin
        logic [1:0] opR;
        int nb;
        int doneSeen;

        rst = 1'b1;
        req = 1'b0;
        op = 2'b00;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_outputs", 32'({done, rd_data, busy_flag, addr, timeout, lcd_rs, lcd_rw, lcd_en}), 32'd0);
        rst = 1'b0;

        respQ = '{8'h45};
        applyStimulus(2'b00, 1'b1, -1);

        respQ = '{8'hA5};
        applyStimulus(2'b01, 1'b1, -1);

        respQ = '{8'h80 | 8'($urandom), 8'h80 | 8'($urandom), 8'h80 | 8'($urandom), 8'h08};
        applyStimulus(2'b10, 1'b1, -1);

        stuckByte = 8'h80 | 8'($urandom);
        applyStimulus(2'b10, 1'b0, -1);
        stuckByte = 8'h00;

        respQ = '{8'($urandom)};
        applyStimulus(2'b00, 1'b1, -1);

        // Reset while E is high must cut the access short without a done.
        respQ = '{8'h3C};
        @(negedge clk);
        req = 1'b1;
        op = 2'b00;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checkOutput("e_high_before_reset", 32'(lcd_en), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("reset_drops_e", 32'(lcd_en), 32'd0);
        checkOutput("reset_ready_now", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        mRd = 8'h00;
        mBusy = 1'b0;
        mAddr = 7'h00;
        mTimeout = 1'b0;
        doneSeen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("no_done_after_reset", 32'(doneSeen), 32'd0);
        checkOutput("rd_data_after_reset", 32'(rd_data), 32'd0);
        respQ.delete();
        respQ = '{8'($urandom)};
        applyStimulus(2'b00, 1'b1, -1);

        respQ = '{8'($urandom)};
        applyStimulus(2'b01, 1'b1, 5);

        for (int i = 0; i < 16; i++) begin
            opR = 2'($urandom_range(0, 3));
            if (opR == 2'b10) begin
                nb = $urandom_range(0, 3);
                for (int j = 0; j < nb; j++) respQ.push_back(8'h80 | 8'($urandom));
                respQ.push_back(8'h7F & 8'($urandom));
            end else begin
                respQ.push_back(8'($urandom));
            end
            applyStimulus(opR, 1'b1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
